// File: rtl/prbs8_checker_if.sv
// Stream and status signals between a PRBS8 source/monitor and the checker.
interface prbs8_checker_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             in_valid;
  logic             in_bit;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;
  logic [1:0]       state;

  // Source side: drives the stream and counter clear, observes status.
  modport master (
    output in_valid, in_bit, clr_cnt,
    input  locked, err_pulse, err_count, bit_count, state
  );

  // Checker side.
  modport slave (
    input  in_valid, in_bit, clr_cnt,
    output locked, err_pulse, err_count, bit_count, state
  );
endinterface

// File: rtl/prbs8_checker.sv
// Self-seeding serial checker for the 8-bit LFSR stream (taps 7,5,4,3).
// Loads 8 bits, qualifies LOCK_CNT matching bits, then free-runs and counts
// errors; too many errors inside one window drops lock and reloads.
module prbs8_checker #(
  parameter int unsigned LOCK_CNT = 16,
  parameter int unsigned ERR_WIN  = 64,
  parameter int unsigned ERR_MAX  = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic           clock,
  input  logic           reset,
  prbs8_checker_if.slave chk
);

  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned WIN_W   = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;
  localparam int unsigned WERR_W  = $clog2(ERR_MAX + 1);
  localparam int unsigned WSUM_W  = WERR_W + 1;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         hist_q, hist_d;
  logic [2:0]         fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0]  win_err_q, win_err_d;
  logic               locked_q, locked_d;
  logic               err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic [CNT_W-1:0]   bit_count_q, bit_count_d;

  logic               pred;
  logic               bit_err;
  logic               cnt_bit;
  logic               cnt_err;
  logic [MATCH_W-1:0] match_inc;
  logic [WSUM_W-1:0]  win_err_sum;

  assign pred        = hist_q[7] ^ hist_q[5] ^ hist_q[4] ^ hist_q[3];
  assign bit_err     = chk.in_bit ^ pred;
  assign match_inc   = match_q + MATCH_W'(1);
  assign win_err_sum = WSUM_W'(win_err_q) + WSUM_W'(bit_err);

  // State and status registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      hist_q      <= 8'h00;
      fill_q      <= '0;
      match_q     <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      bit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;
    end
  end

  // Next-state: load, qualify, then free-run with windowed error budget.
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_pulse_d = 1'b0;
    cnt_bit     = 1'b0;
    cnt_err     = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (chk.in_valid) begin
          hist_d = {hist_q[6:0], chk.in_bit};
          fill_d = fill_q + 3'd1;
          if (fill_q == 3'd7) begin
            state_d = ST_SYNC;
            match_d = '0;
          end
        end
      end
      ST_SYNC: begin
        if (chk.in_valid) begin
          hist_d = {hist_q[6:0], chk.in_bit};
          // All-zero history is the LFSR lock-up pattern and never qualifies.
          if ((hist_q == 8'h00) || bit_err) begin
            match_d = '0;
          end else if (match_inc == MATCH_W'(LOCK_CNT)) begin
            state_d   = ST_LOCKED;
            match_d   = '0;
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            match_d = match_inc;
          end
        end
      end
      ST_LOCKED: begin
        if (chk.in_valid) begin
          // Free-running history so a single flipped bit is one error.
          hist_d      = {hist_q[6:0], pred};
          cnt_bit     = 1'b1;
          cnt_err     = bit_err;
          err_pulse_d = bit_err;
          if (bit_err && (win_err_sum >= WSUM_W'(ERR_MAX))) begin
            state_d = ST_LOAD;
            fill_d  = '0;
          end else if (win_cnt_q == WIN_W'(ERR_WIN - 1)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            win_err_d = WERR_W'(win_err_sum);
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
        fill_d  = '0;
      end
    endcase

    locked_d = (state_d == ST_LOCKED);

    // Saturating counters; clear wins over a same-cycle increment.
    err_count_d = err_count_q;
    bit_count_d = bit_count_q;
    if (chk.clr_cnt) begin
      err_count_d = '0;
      bit_count_d = '0;
    end else begin
      if (cnt_err && (err_count_q != {CNT_W{1'b1}})) err_count_d = err_count_q + CNT_W'(1);
      if (cnt_bit && (bit_count_q != {CNT_W{1'b1}})) bit_count_d = bit_count_q + CNT_W'(1);
    end
  end

  assign chk.locked    = locked_q;
  assign chk.err_pulse = err_pulse_q;
  assign chk.err_count = err_count_q;
  assign chk.bit_count = bit_count_q;
  assign chk.state     = state_q;

endmodule

// File: tb/tb_prbs8_checker.sv
// Directed bench for prbs8_checker: per-cycle expectations go through a
// scoreboard queue; a monitor pops and compares locked/err_pulse.
module tb_prbs8_checker;

  localparam int unsigned CNT_W = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  prbs8_checker_if #(.CNT_W(CNT_W)) bus ();

  prbs8_checker #(
    .LOCK_CNT (16),
    .ERR_WIN  (64),
    .ERR_MAX  (4),
    .CNT_W    (CNT_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .chk   (bus)
  );

  typedef struct {
    logic  lk;
    logic  pl;
    string tag;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] gen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus; pushes the expected post-edge locked/err_pulse.
  task automatic step(input logic v, input logic flip, input logic zero,
                      input logic rst, input logic clr,
                      input logic exp_lk, input logic exp_pl, input string tag);
    logic fb;
    exp_t e;
    @(negedge clock);
    reset        = rst;
    bus.clr_cnt  = clr;
    bus.in_valid = v;
    if (v && !zero) begin
      fb         = gen[7] ^ gen[5] ^ gen[4] ^ gen[3];
      gen        = {gen[6:0], fb};
      bus.in_bit = fb ^ flip;
    end else if (v) begin
      bus.in_bit = 1'b0;
    end else begin
      bus.in_bit = 1'($urandom_range(0, 1));
    end
    e.lk  = exp_lk;
    e.pl  = exp_pl;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clock);
    #2;
  endtask

  // Monitor: compare outputs one step after each clocked cycle of stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, " locked"}, 32'(bus.locked), 32'(e.lk));
        check({e.tag, " err_pulse"}, 32'(bus.err_pulse), 32'(e.pl));
      end
    end
  end

  initial begin
    int  nv;
    logic v;
    logic f;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    bus.clr_cnt  = 1'b0;
    gen          = 8'h01;

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "reset");
    check("reset state", 32'(bus.state), 32'd0);
    check("reset err_count", 32'(bus.err_count), 32'd0);
    check("reset bit_count", 32'(bus.bit_count), 32'd0);

    // Initial acquisition from seed 8'h01
    for (int n = 1; n <= 30; n++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, (n >= 24), 1'b0, "acq");
      if (n == 7) check("acq state LOAD at bit 7", 32'(bus.state), 32'd0);
      if (n == 8) check("acq state SYNC at bit 8", 32'(bus.state), 32'd1);
    end
    check("acq state", 32'(bus.state), 32'd2);
    check("acq err_count", 32'(bus.err_count), 32'd0);
    check("acq bit_count", 32'(bus.bit_count), 32'd6);

    // Locked bits 7..215: single error, 3+3 across a window edge, clear, loss of lock
    for (int l = 7; l <= 215; l++) begin
      f = (l == 7) || (l == 30) || (l == 60) || (l == 70) || (l == 100) || (l == 128) ||
          (l == 141) || (l == 195) || (l == 200) || (l == 210) || (l == 215);
      step(1'b1, f, 1'b0, 1'b0, (l == 141), (l < 215), f, "locked");
      if (l == 7) begin
        check("single err err_count", 32'(bus.err_count), 32'd1);
        check("single err bit_count", 32'(bus.bit_count), 32'd7);
      end
      if (l == 140) begin
        check("3+3 err_count", 32'(bus.err_count), 32'd6);
        check("3+3 bit_count", 32'(bus.bit_count), 32'd140);
        check("3+3 state", 32'(bus.state), 32'd2);
      end
      if (l == 141) begin
        check("clr with err err_count", 32'(bus.err_count), 32'd0);
        check("clr with err bit_count", 32'(bus.bit_count), 32'd0);
        check("clr with err state", 32'(bus.state), 32'd2);
      end
      if (l == 142) check("after clr bit_count", 32'(bus.bit_count), 32'd1);
      if (l == 214) check("3 of 4 err_count", 32'(bus.err_count), 32'd3);
      if (l == 215) begin
        check("loss state", 32'(bus.state), 32'd0);
        check("loss err_count", 32'(bus.err_count), 32'd4);
        check("loss bit_count", 32'(bus.bit_count), 32'd74);
      end
    end

    // Re-lock 24 valid bits after loss
    for (int n = 1; n <= 30; n++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, (n >= 24), 1'b0, "relock");
      if (n == 8) check("relock state SYNC", 32'(bus.state), 32'd1);
    end
    check("relock state", 32'(bus.state), 32'd2);
    check("relock bit_count", 32'(bus.bit_count), 32'd80);
    check("relock err_count", 32'(bus.err_count), 32'd4);

    // Reset mid-LOCKED, coinciding with an errored bit
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "reset mid");
    check("reset mid state", 32'(bus.state), 32'd0);
    check("reset mid err_count", 32'(bus.err_count), 32'd0);
    check("reset mid bit_count", 32'(bus.bit_count), 32'd0);

    // All-zero stream never locks
    for (int n = 1; n <= 200; n++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "zeros");
      if (n == 8) check("zeros state SYNC", 32'(bus.state), 32'd1);
    end
    check("zeros final state", 32'(bus.state), 32'd1);

    // Good stream with random valid gaps: lock point counted in valid bits
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "gap reset");
    gen = 8'h5C;
    nv  = 0;
    for (int c = 0; (c < 200) && (nv < 30); c++) begin
      v = ($urandom_range(0, 2) != 0);
      if (v) nv++;
      step(v, 1'b0, 1'b0, 1'b0, 1'b0, (nv >= 24), 1'b0, "gaps");
    end
    check("gaps valid bits issued", 32'(nv), 32'd30);
    check("gaps state", 32'(bus.state), 32'd2);
    check("gaps bit_count", 32'(bus.bit_count), 32'd6);

    bus.in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
